// File: rtl/wd279x_read_sequencer_if.sv
// Signal bundle shared by the WD279x read sequencer, the demodulator
// and the CPU-side register file / command decoder.
interface wd279x_read_sequencer_if;
   logic            cmd_start;
   logic            cmd_multi;
   logic            cmd_side_cmp;
   logic            cmd_side;
   logic            force_int;
   logic [7:0]      track_reg;
   logic [7:0]      sector_in;
   logic            INDEXn;
   logic [5:0][7:0] IDAM_data;
   logic            IDAM_valid;
   logic            DAM_valid;
   logic            DAM_deleted;
   logic            DAM_CRC_valid;
   logic [7:0]      fdd_data;
   logic            fdd_rx;
   logic            data_rd;
   logic [7:0]      data_out;
   logic [7:0]      sector_out;
   logic            busy;
   logic            drq;
   logic            rnf;
   logic            crc_err;
   logic            lost_data;
   logic            rec_type;
   logic            intrq;

   modport slave (
      input  cmd_start, cmd_multi, cmd_side_cmp, cmd_side, force_int,
      input  track_reg, sector_in, INDEXn, IDAM_data, IDAM_valid,
      input  DAM_valid, DAM_deleted, DAM_CRC_valid, fdd_data, fdd_rx, data_rd,
      output data_out, sector_out, busy, drq, rnf, crc_err, lost_data,
      output rec_type, intrq
   );

   modport master (
      output cmd_start, cmd_multi, cmd_side_cmp, cmd_side, force_int,
      output track_reg, sector_in, INDEXn, IDAM_data, IDAM_valid,
      output DAM_valid, DAM_deleted, DAM_CRC_valid, fdd_data, fdd_rx, data_rd,
      input  data_out, sector_out, busy, drq, rnf, crc_err, lost_data,
      input  rec_type, intrq
   );
endinterface

// File: rtl/wd279x_read_sequencer.sv
// WD279x Read Sector sequencer: finds the requested ID, moves the data field
// to the CPU data register under DRQ handshake and reports completion status.
module wd279x_read_sequencer #(
   parameter int IDX_LIMIT  = 5,
   parameter int DAM_WINDOW = 43
) (
   input  logic                    clk,
   input  logic                    reset,
   wd279x_read_sequencer_if.slave  bus
);
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SEARCH   = 3'd1;
   localparam logic [2:0] ST_WAIT_DAM = 3'd2;
   localparam logic [2:0] ST_XFER     = 3'd3;
   localparam logic [2:0] ST_CRC      = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   localparam int IDX_W = $clog2(IDX_LIMIT + 1);
   localparam int WIN_W = $clog2(DAM_WINDOW + 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(IDX_LIMIT);
   localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(DAM_WINDOW);

   logic [2:0]       state_q, state_d;
   logic             multi_q, multi_d;
   logic             side_cmp_q, side_cmp_d;
   logic             side_q, side_d;
   logic [7:0]       track_q, track_d;
   logic [7:0]       sector_q, sector_d;
   logic [IDX_W-1:0] idx_cnt_q, idx_cnt_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [10:0]      len_q, len_d;
   logic [10:0]      byte_cnt_q, byte_cnt_d;
   logic [1:0]       crc_cnt_q, crc_cnt_d;
   logic [7:0]       data_out_q, data_out_d;
   logic             busy_q, busy_d;
   logic             drq_q, drq_d;
   logic             rnf_q, rnf_d;
   logic             crc_err_q, crc_err_d;
   logic             lost_q, lost_d;
   logic             rec_type_q, rec_type_d;
   logic             intrq_q, intrq_d;
   logic             idx_prev_q, idam_prev_q, dam_prev_q;

   logic             idx_fall_s, idam_rise_s, dam_rise_s, dam_fall_s;
   logic             id_match_s, idx_hit_s, start_s, counting_s;
   logic [IDX_W-1:0] idx_inc_s;
   logic [WIN_W-1:0] win_inc_s;
   logic             unused_s;

   assign idx_fall_s  = idx_prev_q & ~bus.INDEXn;
   assign idam_rise_s = bus.IDAM_valid & ~idam_prev_q;
   assign dam_rise_s  = bus.DAM_valid & ~dam_prev_q;
   assign dam_fall_s  = dam_prev_q & ~bus.DAM_valid;
   assign idx_inc_s   = idx_cnt_q + IDX_W'(1);
   assign win_inc_s   = win_cnt_q + WIN_W'(1);
   assign counting_s  = (state_q == ST_SEARCH) || (state_q == ST_WAIT_DAM);
   assign idx_hit_s   = idx_fall_s && (idx_inc_s >= IDX_MAX);
   assign start_s     = bus.cmd_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign id_match_s  = (bus.IDAM_data[0] == track_q) && (bus.IDAM_data[2] == sector_q) &&
                        (!side_cmp_q || (bus.IDAM_data[1][0] == side_q));
   // CRC and unused header bits are checked by the demodulator, not here
   assign unused_s    = ^{bus.IDAM_data[5], bus.IDAM_data[4], bus.IDAM_data[3][7:2],
                          bus.IDAM_data[1][7:1]};

   // Next-state and status update for the Read Sector command
   always_comb begin
      state_d    = state_q;
      multi_d    = multi_q;
      side_cmp_d = side_cmp_q;
      side_d     = side_q;
      track_d    = track_q;
      sector_d   = sector_q;
      win_cnt_d  = win_cnt_q;
      len_d      = len_q;
      byte_cnt_d = byte_cnt_q;
      crc_cnt_d  = crc_cnt_q;
      data_out_d = data_out_q;
      busy_d     = busy_q;
      rnf_d      = rnf_q;
      crc_err_d  = crc_err_q;
      lost_d     = lost_q;
      rec_type_d = rec_type_q;
      intrq_d    = intrq_q;
      idx_cnt_d  = (idx_fall_s && counting_s) ? idx_inc_s : idx_cnt_q;
      if (bus.data_rd) begin
         drq_d = 1'b0;
      end else begin
         drq_d = drq_q;
      end

      if (bus.force_int) begin
         intrq_d = 1'b1;
         if (state_q != ST_IDLE) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            drq_d   = 1'b0;
         end else begin
            state_d = state_q;
         end
      end else if (start_s) begin
         multi_d    = bus.cmd_multi;
         side_cmp_d = bus.cmd_side_cmp;
         side_d     = bus.cmd_side;
         track_d    = bus.track_reg;
         sector_d   = bus.sector_in;
         rnf_d      = 1'b0;
         crc_err_d  = 1'b0;
         lost_d     = 1'b0;
         rec_type_d = 1'b0;
         drq_d      = 1'b0;
         intrq_d    = 1'b0;
         busy_d     = 1'b1;
         idx_cnt_d  = '0;
         state_d    = ST_SEARCH;
      end else begin
         case (state_q)
            ST_IDLE: begin
               intrq_d = 1'b0;
            end
            ST_SEARCH: begin
               if (idx_hit_s) begin
                  rnf_d   = 1'b1;
                  busy_d  = 1'b0;
                  intrq_d = 1'b1;
                  state_d = ST_DONE;
               end else if (idam_rise_s && id_match_s) begin
                  len_d     = 11'd128 << bus.IDAM_data[3][1:0];
                  win_cnt_d = '0;
                  state_d   = ST_WAIT_DAM;
               end else begin
                  state_d = state_q;
               end
            end
            ST_WAIT_DAM: begin
               if (idx_hit_s) begin
                  rnf_d   = 1'b1;
                  busy_d  = 1'b0;
                  intrq_d = 1'b1;
                  state_d = ST_DONE;
               end else if (dam_rise_s) begin
                  rec_type_d = bus.DAM_deleted;
                  byte_cnt_d = len_q;
                  state_d    = ST_XFER;
               end else if (bus.fdd_rx) begin
                  win_cnt_d = win_inc_s;
                  state_d   = (win_inc_s >= WIN_MAX) ? ST_SEARCH : state_q;
               end else begin
                  state_d = state_q;
               end
            end
            ST_XFER: begin
               // a dropped DAM before the last byte means the demodulator lost sync
               if (dam_fall_s) begin
                  state_d = ST_SEARCH;
               end else if (bus.fdd_rx && bus.DAM_valid) begin
                  data_out_d = bus.fdd_data;
                  drq_d      = 1'b1;
                  lost_d     = lost_q | (drq_q & ~bus.data_rd);
                  byte_cnt_d = byte_cnt_q - 11'd1;
                  if (byte_cnt_q == 11'd1) begin
                     crc_cnt_d = 2'd2;
                     state_d   = ST_CRC;
                  end else begin
                     state_d = state_q;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_CRC: begin
               if (crc_cnt_q == 2'd0) begin
                  if (!bus.DAM_CRC_valid) begin
                     crc_err_d = 1'b1;
                     busy_d    = 1'b0;
                     intrq_d   = 1'b1;
                     state_d   = ST_DONE;
                  end else if (multi_q) begin
                     sector_d  = sector_q + 8'd1;
                     idx_cnt_d = '0;
                     state_d   = ST_SEARCH;
                  end else begin
                     busy_d  = 1'b0;
                     intrq_d = 1'b1;
                     state_d = ST_DONE;
                  end
               end else if (bus.fdd_rx) begin
                  crc_cnt_d = crc_cnt_q - 2'd1;
               end else begin
                  crc_cnt_d = crc_cnt_q;
               end
            end
            ST_DONE: begin
               busy_d  = 1'b0;
               intrq_d = 1'b1;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters, status registers and input edge detectors
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         multi_q     <= 1'b0;
         side_cmp_q  <= 1'b0;
         side_q      <= 1'b0;
         track_q     <= 8'd0;
         sector_q    <= 8'd0;
         idx_cnt_q   <= '0;
         win_cnt_q   <= '0;
         len_q       <= 11'd0;
         byte_cnt_q  <= 11'd0;
         crc_cnt_q   <= 2'd0;
         data_out_q  <= 8'd0;
         busy_q      <= 1'b0;
         drq_q       <= 1'b0;
         rnf_q       <= 1'b0;
         crc_err_q   <= 1'b0;
         lost_q      <= 1'b0;
         rec_type_q  <= 1'b0;
         intrq_q     <= 1'b0;
         idx_prev_q  <= 1'b1;
         idam_prev_q <= 1'b0;
         dam_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         multi_q     <= multi_d;
         side_cmp_q  <= side_cmp_d;
         side_q      <= side_d;
         track_q     <= track_d;
         sector_q    <= sector_d;
         idx_cnt_q   <= idx_cnt_d;
         win_cnt_q   <= win_cnt_d;
         len_q       <= len_d;
         byte_cnt_q  <= byte_cnt_d;
         crc_cnt_q   <= crc_cnt_d;
         data_out_q  <= data_out_d;
         busy_q      <= busy_d;
         drq_q       <= drq_d;
         rnf_q       <= rnf_d;
         crc_err_q   <= crc_err_d;
         lost_q      <= lost_d;
         rec_type_q  <= rec_type_d;
         intrq_q     <= intrq_d;
         idx_prev_q  <= bus.INDEXn;
         idam_prev_q <= bus.IDAM_valid;
         dam_prev_q  <= bus.DAM_valid;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.sector_out = sector_q;
   assign bus.busy       = busy_q;
   assign bus.drq        = drq_q;
   assign bus.rnf        = rnf_q;
   assign bus.crc_err    = crc_err_q;
   assign bus.lost_data  = lost_q;
   assign bus.rec_type   = rec_type_q;
   assign bus.intrq      = intrq_q;
endmodule

// File: tb/tb_wd279x_read_sequencer.sv
// Randomized self-checking bench for wd279x_read_sequencer: disk streams are
// generated here and the expected data, DRQ and status are computed alongside.
module tb_wd279x_read_sequencer;
   localparam int IDX_LIMIT  = 5;
   localparam int DAM_WINDOW = 43;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   // expected-behaviour bookkeeping
   logic       lost_exp;
   int         prev_mode;
   logic [7:0] last_byte;
   int         drq_seen;

   wd279x_read_sequencer_if bus();

   wd279x_read_sequencer #(.IDX_LIMIT(IDX_LIMIT), .DAM_WINDOW(DAM_WINDOW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {busy, drq, rnf, crc_err, lost_data, rec_type, intrq}
   function automatic logic [6:0] status();
      return {bus.busy, bus.drq, bus.rnf, bus.crc_err, bus.lost_data, bus.rec_type, bus.intrq};
   endfunction

   task automatic start_cmd(input logic m, input logic sc, input logic s,
                            input logic [7:0] trk, input logic [7:0] sec);
      bus.cmd_multi = m; bus.cmd_side_cmp = sc; bus.cmd_side = s;
      bus.track_reg = trk; bus.sector_in = sec;
      bus.cmd_start = 1'b1;
      tick();
      bus.cmd_start = 1'b0;
      // only the latched copies may matter from here on
      bus.track_reg = 8'($urandom); bus.sector_in = 8'($urandom);
      bus.cmd_multi = ~m; bus.cmd_side_cmp = ~sc; bus.cmd_side = ~s;
      check_eq("start_status", 32'(status()), 32'(7'b1000000));
      lost_exp  = 1'b0;
      prev_mode = 1;
      drq_seen  = 0;
   endtask

   task automatic send_id(input logic [7:0] trk, input logic side, input logic [7:0] sec,
                          input logic [1:0] lc);
      bus.IDAM_data  = {8'hA5, 8'h5A, {6'd0, lc}, sec, {7'd0, side}, trk};
      bus.IDAM_valid = 1'b1;
      tick(); tick();
      bus.IDAM_valid = 1'b0;
      tick();
   endtask

   task automatic filler(input int n);
      for (int i = 0; i < n; i++) begin
         bus.fdd_data = 8'($urandom); bus.fdd_rx = 1'b1;
         tick();
         bus.fdd_rx = 1'b0;
         tick();
      end
   endtask

   task automatic junk_field(input int n);
      bus.DAM_deleted = 1'($urandom); bus.DAM_valid = 1'b1;
      tick();
      filler(n);
      bus.DAM_valid = 1'b0;
      tick();
   endtask

   task automatic index_pulse();
      bus.INDEXn = 1'b0;
      tick();
      bus.INDEXn = 1'b1;
      tick();
   endtask

   // rd_style: 0 never read, 1 read promptly, 2 random (incl. read coinciding with next byte)
   task automatic xfer_sector(input int n, input int rd_style, input logic crc_ok,
                              input logic del, input logic close_field);
      int         m;
      logic [7:0] b;
      bus.DAM_deleted = del; bus.DAM_CRC_valid = crc_ok; bus.DAM_valid = 1'b1;
      tick();
      for (int i = 0; i < n; i++) begin
         m = (rd_style == 2) ? int'($urandom_range(2, 0)) : rd_style;
         if (i == n - 1 && m == 2) m = 1;
         b = 8'($urandom);
         bus.fdd_data = b; bus.fdd_rx = 1'b1; bus.data_rd = (prev_mode == 2);
         tick();
         bus.fdd_rx = 1'b0; bus.data_rd = 1'b0;
         if (prev_mode == 0) lost_exp = 1'b1;
         check_eq("data_out", 32'(bus.data_out), 32'(b));
         check_eq("drq_set", 32'(bus.drq), 32'd1);
         check_eq("lost_data", 32'(bus.lost_data), 32'(lost_exp));
         drq_seen += int'(bus.drq);
         last_byte = b;
         if (m == 1) begin
            bus.data_rd = 1'b1;
            tick();
            bus.data_rd = 1'b0;
            check_eq("drq_clr", 32'(bus.drq), 32'd0);
         end
         tick();
         prev_mode = m;
      end
      if (close_field) begin
         filler(2);
         tick();
         bus.DAM_valid = 1'b0;
         tick();
      end
   endtask

   initial begin
      logic [7:0] trk, sec, old_byte;
      logic       side, del;
      logic [1:0] lc;
      bus.cmd_start = 1'b0; bus.cmd_multi = 1'b0; bus.cmd_side_cmp = 1'b0; bus.cmd_side = 1'b0;
      bus.force_int = 1'b0; bus.track_reg = 8'd0; bus.sector_in = 8'd0; bus.INDEXn = 1'b1;
      bus.IDAM_data = '0; bus.IDAM_valid = 1'b0; bus.DAM_valid = 1'b0; bus.DAM_deleted = 1'b0;
      bus.DAM_CRC_valid = 1'b1; bus.fdd_data = 8'd0; bus.fdd_rx = 1'b0; bus.data_rd = 1'b0;
      lost_exp = 1'b0; prev_mode = 1; last_byte = 8'd0; drq_seen = 0;

      reset = 1'b1;
      repeat (3) tick();
      check_eq("reset_status", 32'(status()), 32'd0);
      check_eq("reset_data_out", 32'(bus.data_out), 32'd0);
      check_eq("reset_sector_out", 32'(bus.sector_out), 32'd0);
      reset = 1'b0;
      tick();

      // force_int in IDLE only pulses intrq
      bus.force_int = 1'b1;
      tick();
      bus.force_int = 1'b0;
      check_eq("idle_force_status", 32'(status()), 32'(7'b0000001));
      tick();
      check_eq("idle_force_release", 32'(bus.intrq), 32'd0);

      // track 5, sector 3 behind sectors 1 and 2, 256-byte sectors, prompt reads
      del = 1'($urandom);
      start_cmd(1'b0, 1'b0, 1'b0, 8'd5, 8'd3);
      send_id(8'd5, 1'b0, 8'd1, 2'd1); junk_field(16);
      send_id(8'd5, 1'b0, 8'd2, 2'd1); junk_field(16);
      check_eq("skip_status", 32'(status()), 32'(7'b1000000));
      send_id(8'd5, 1'($urandom), 8'd3, 2'd1);
      filler(int'($urandom_range(20, 0)));
      xfer_sector(256, 1, 1'b1, del, 1'b1);
      check_eq("drq_count", 32'(drq_seen), 32'd256);
      check_eq("t1_status", 32'(status()), 32'({5'b00000, del, 1'b1}));
      check_eq("t1_data_out", 32'(bus.data_out), 32'(last_byte));
      check_eq("t1_sector_out", 32'(bus.sector_out), 32'd3);

      // record not found: near-miss IDs, then IDX_LIMIT index pulses
      trk = 8'($urandom); sec = 8'($urandom); side = 1'($urandom);
      start_cmd(1'b0, 1'b1, side, trk, sec);
      start_cmd(1'b0, 1'b0, ~side, trk ^ 8'h01, sec + 8'd1);
      check_eq("busy_start_ignored", 32'(bus.sector_out), 32'(sec));
      send_id(trk ^ 8'h01, side, sec, 2'd0);
      send_id(trk, ~side, sec, 2'd0);
      send_id(trk, side, sec + 8'd1, 2'd0);
      for (int k = 1; k <= IDX_LIMIT; k++) begin
         index_pulse();
         if (k < IDX_LIMIT) check_eq("rnf_pending", 32'(status()), 32'(7'b1000000));
      end
      check_eq("rnf_status", 32'(status()), 32'(7'b0010001));

      // CPU never reads: lost data from the second byte, transfer still completes
      trk = 8'($urandom); sec = 8'($urandom);
      start_cmd(1'b0, 1'b0, 1'b0, trk, sec);
      send_id(trk, 1'($urandom), sec, 2'd0);
      xfer_sector(128, 0, 1'b1, 1'b0, 1'b1);
      check_eq("lost_status", 32'(status()), 32'(7'b0100101));
      check_eq("lost_data_out", 32'(bus.data_out), 32'(last_byte));

      // random read timing, random sector size
      trk = 8'($urandom); sec = 8'($urandom); side = 1'($urandom); lc = 2'($urandom_range(2, 0));
      del = 1'($urandom);
      start_cmd(1'b0, 1'b1, side, trk, sec);
      send_id(trk, side, sec, lc);
      xfer_sector(128 << lc, 2, 1'b1, del, 1'b1);
      check_eq("rand_status", 32'(status()),
               32'({1'b0, (prev_mode == 0), 2'b00, lost_exp, del, 1'b1}));

      // bad data CRC in multi mode: sector does not advance
      trk = 8'($urandom); sec = 8'($urandom); del = 1'($urandom);
      start_cmd(1'b1, 1'b0, 1'b0, trk, sec);
      send_id(trk, 1'b0, sec, 2'd0);
      xfer_sector(128, 1, 1'b0, del, 1'b1);
      check_eq("crc_status", 32'(status()), 32'({4'b0001, 1'b0, del, 1'b1}));
      check_eq("crc_sector_out", 32'(bus.sector_out), 32'(sec));

      // multi-sector 1..3, then record not found on sector 4
      trk = 8'($urandom);
      start_cmd(1'b1, 1'b0, 1'b0, trk, 8'd1);
      repeat (3) index_pulse();
      for (int s = 1; s <= 3; s++) begin
         send_id(trk, 1'b0, 8'(s), 2'($urandom_range(1, 0)));
         xfer_sector(128 << bus.IDAM_data[3][1:0], 1, 1'b1, 1'b0, 1'b1);
         check_eq("multi_sector_out", 32'(bus.sector_out), 32'(s + 1));
         check_eq("multi_status", 32'(status()), 32'(7'b1000000));
      end
      for (int s = 1; s <= 3; s++) send_id(trk, 1'b0, 8'(s), 2'd0);
      for (int k = 1; k <= IDX_LIMIT; k++) begin
         index_pulse();
         if (k < IDX_LIMIT) check_eq("multi_rnf_pending", 32'(status()), 32'(7'b1000000));
      end
      check_eq("multi_rnf_status", 32'(status()), 32'(7'b0010001));
      check_eq("multi_final_sector", 32'(bus.sector_out), 32'd4);

      // DAM window: 43 bytes expires the match, 42 bytes still accepts
      trk = 8'($urandom); sec = 8'($urandom);
      start_cmd(1'b0, 1'b0, 1'b0, trk, sec);
      send_id(trk, 1'b0, sec, 2'd0);
      filler(DAM_WINDOW);
      junk_field(8);
      check_eq("window_expired", 32'(status()), 32'(7'b1000000));
      send_id(trk, 1'b0, sec, 2'd0);
      filler(DAM_WINDOW - 1);
      xfer_sector(128, 1, 1'b1, 1'b0, 1'b1);
      check_eq("window_status", 32'(status()), 32'(7'b0000001));

      // DAM drops mid-sector: back to search, later field completes normally
      trk = 8'($urandom); sec = 8'($urandom);
      start_cmd(1'b0, 1'b0, 1'b0, trk, sec);
      send_id(trk, 1'b0, sec, 2'd0);
      xfer_sector(5, 1, 1'b1, 1'b0, 1'b0);
      bus.DAM_valid = 1'b0;
      tick();
      old_byte = last_byte;
      bus.DAM_valid = 1'b1;
      tick();
      filler(1);
      bus.DAM_valid = 1'b0;
      tick();
      check_eq("resync_data_kept", 32'(bus.data_out), 32'(old_byte));
      check_eq("resync_status", 32'(status()), 32'(7'b1000000));
      send_id(trk, 1'b0, sec, 2'd0);
      xfer_sector(128, 1, 1'b1, 1'b0, 1'b1);
      check_eq("resync_done", 32'(status()), 32'(7'b0000001));

      // force_int at byte 10, then asynchronous reset
      trk = 8'($urandom); sec = 8'($urandom); del = 1'($urandom);
      start_cmd(1'b0, 1'b0, 1'b0, trk, sec);
      send_id(trk, 1'b0, sec, 2'd1);
      xfer_sector(10, 0, 1'b1, del, 1'b0);
      bus.force_int = 1'b1;
      tick();
      bus.force_int = 1'b0;
      check_eq("force_status", 32'(status()), 32'({4'b0000, 1'b1, del, 1'b1}));
      tick();
      check_eq("force_hold", 32'(status()), 32'({4'b0000, 1'b1, del, 1'b1}));
      bus.DAM_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_reset_status", 32'(status()), 32'd0);
      check_eq("async_reset_data", 32'(bus.data_out), 32'd0);
      check_eq("async_reset_sector", 32'(bus.sector_out), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
